// File: rtl/uart_pkg.sv
// Shared UART constants, receive-record layout and small helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package uart_pkg;

    // Receive/transmit FIFO geometry
    localparam int FIFO_DEPTH     = 16;
    localparam int FIFO_POINTER_W = 4;
    localparam int FIFO_COUNTER_W = 5;
    localparam int FIFO_REC_WIDTH = 11;
    localparam int FIFO_WIDTH     = 8;

    // Error-flag positions inside a receive record
    localparam int ERR_BREAK_IDX   = 2;
    localparam int ERR_PARITY_IDX  = 1;
    localparam int ERR_FRAMING_IDX = 0;
    localparam int ERR_W           = 3;

    typedef logic [FIFO_POINTER_W-1:0] ptr_t;
    typedef logic [FIFO_COUNTER_W-1:0] cnt_t;
    typedef logic [FIFO_REC_WIDTH-1:0] rec_bits_t;

    // Receive record: {data[7:0], break, parity_err, framing_err}
    typedef struct packed {
        logic [7:0] data;
        logic       brk;
        logic       parity_err;
        logic       framing_err;
    } rx_rec_t;

    // True when a record carries any line error.
    function automatic logic rec_has_err(input rx_rec_t rec);
        return rec.brk | rec.parity_err | rec.framing_err;
    endfunction

    // True when a slot lies inside the live window rd .. rd+cnt-1 (mod depth).
    function automatic logic slot_valid(input ptr_t slot, input ptr_t rd, input cnt_t cnt);
        ptr_t offset;
        offset = slot - rd;
        return ({1'b0, offset} < cnt);
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Register-file storage for the UART FIFOs: one synchronous write, one async read.
// Latency: write visible on the read port the cycle after we_i; read is combinational.
// Backpressure: none; the caller only asserts we_i for accepted writes.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int WIDTH = FIFO_REC_WIDTH,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_POINTER_W
) (
    input  logic                        clk,
    input  logic                        wb_rst_i,
    input  logic                        we_i,
    input  logic [AW-1:0]               waddr_i,
    input  logic [WIDTH-1:0]            wdata_i,
    input  logic [AW-1:0]               raddr_i,
    output logic [WIDTH-1:0]            rdata_o,
    output logic [DEPTH-1:0][WIDTH-1:0] mem_o
);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;

    // Storage array; cleared by the global reset so data_out reads zero afterwards.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read port and full-array view for the error scan.
    always_comb begin
        rdata_o = mem_q[raddr_i];
        mem_o   = mem_q;
    end

endmodule

// File: rtl/uart_status_fifo.sv
// 16-entry receive FIFO holding characters plus error flags, with count and sticky status.
// Latency: pushed entry reaches data_out next cycle when empty; new head appears next cycle after pop.
// Backpressure: none; push when full is dropped and flags overrun, pop when empty flags underrun.
module uart_status_fifo
    import uart_pkg::*;
(
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic [FIFO_REC_WIDTH-1:0] data_in,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      fifo_reset,
    input  logic                      reset_status,
    output logic [FIFO_REC_WIDTH-1:0] data_out,
    output logic [FIFO_COUNTER_W-1:0] count,
    output logic                      overrun,
    output logic                      underrun,
    output logic                      error_bit
);

    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t wr_ptr_q, wr_ptr_d;
    cnt_t count_q, count_d;
    logic overrun_q, overrun_d;
    logic underrun_q, underrun_d;

    logic full, empty;
    logic push_ok, pop_ok;
    logic ovr_evt, und_evt;
    logic ram_we;
    logic err_scan;

    rec_bits_t                       ram_rdata;
    logic [FIFO_DEPTH-1:0][FIFO_REC_WIDTH-1:0] ram_mem;

    // Accept/reject decisions. A push on a full FIFO is still taken when a pop
    // frees the head in the same cycle; a pop on an empty FIFO is never taken.
    always_comb begin
        full    = (count_q == cnt_t'(FIFO_DEPTH));
        empty   = (count_q == '0);
        push_ok = push & (~full | pop);
        pop_ok  = pop & ~empty;
        ovr_evt = push & full & ~pop;
        und_evt = pop & empty & ~push;
        ram_we  = push_ok & ~fifo_reset;
    end

    // Next-state for pointers, occupancy and sticky flags; flush has top priority,
    // and a new flag event beats a same-cycle status clear.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overrun_d  = overrun_q;
        underrun_d = underrun_q;

        if (fifo_reset) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase

            if (ovr_evt) begin
                overrun_d = 1'b1;
            end else if (reset_status) begin
                overrun_d = 1'b0;
            end

            if (und_evt) begin
                underrun_d = 1'b1;
            end else if (reset_status) begin
                underrun_d = 1'b0;
            end
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    uart_fifo_ram #(
        .WIDTH (FIFO_REC_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_POINTER_W)
    ) u_ram (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .we_i     (ram_we),
        .waddr_i  (wr_ptr_q),
        .wdata_i  (data_in),
        .raddr_i  (rd_ptr_q),
        .rdata_o  (ram_rdata),
        .mem_o    (ram_mem)
    );

    // Error summary over the live window only; stale slots outside it are masked.
    always_comb begin
        err_scan = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slot_valid(ptr_t'(i), rd_ptr_q, count_q) && rec_has_err(rx_rec_t'(ram_mem[i]))) begin
                err_scan = 1'b1;
            end
        end
    end

    // Outputs come straight from registered state.
    always_comb begin
        data_out  = ram_rdata;
        count     = count_q;
        overrun   = overrun_q;
        underrun  = underrun_q;
        error_bit = err_scan;
    end

endmodule

// File: tb/tb_uart_status_fifo.sv
module tb_uart_status_fifo;

    logic        clk;
    logic        wb_rst_i;
    logic [10:0] data_in;
    logic        push;
    logic        pop;
    logic        fifo_reset;
    logic        reset_status;
    logic [10:0] data_out;
    logic [4:0]  count;
    logic        overrun;
    logic        underrun;
    logic        error_bit;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: queue of live entries plus sticky flags
    logic [10:0] mq[$];
    bit          m_ovr;
    bit          m_und;

    uart_status_fifo dut (
        .clk          (clk),
        .wb_rst_i     (wb_rst_i),
        .data_in      (data_in),
        .push         (push),
        .pop          (pop),
        .fifo_reset   (fifo_reset),
        .reset_status (reset_status),
        .data_out     (data_out),
        .count        (count),
        .overrun      (overrun),
        .underrun     (underrun),
        .error_bit    (error_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit model_err();
        bit e;
        e = 1'b0;
        foreach (mq[i]) e |= |mq[i][2:0];
        return e;
    endfunction

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic cyc(input bit pu, input bit po, input logic [10:0] d, input bit fr, input bit rs);
        bit          full;
        bit          empty;
        logic [10:0] exp;
        push         = pu;
        pop          = po;
        data_in      = d;
        fifo_reset   = fr;
        reset_status = rs;
        if (fr) begin
            mq.delete();
            m_ovr = 1'b0;
            m_und = 1'b0;
        end else begin
            full  = (mq.size() == 16);
            empty = (mq.size() == 0);
            if (po && !empty) begin
                exp = mq.pop_front();
                check("pop_data", {21'd0, data_out}, {21'd0, exp});
            end
            if (pu && (!full || po)) mq.push_back(d);
            if (pu && full && !po) m_ovr = 1'b1;
            else if (rs)           m_ovr = 1'b0;
            if (po && empty && !pu) m_und = 1'b1;
            else if (rs)            m_und = 1'b0;
        end
        @(posedge clk);
        #1;
        push         = 1'b0;
        pop          = 1'b0;
        fifo_reset   = 1'b0;
        reset_status = 1'b0;
        check("count", {27'd0, count}, mq.size());
        check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        check("underrun", {31'd0, underrun}, {31'd0, m_und});
        check("error_bit", {31'd0, error_bit}, {31'd0, model_err()});
        if (mq.size() > 0) check("head", {21'd0, data_out}, {21'd0, mq[0]});
    endtask

    task automatic do_push(input logic [10:0] d);
        cyc(1'b1, 1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic do_pop();
        cyc(1'b0, 1'b1, 11'd0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"}, {27'd0, count}, 32'd0);
        check({tag, "_data"}, {21'd0, data_out}, 32'd0);
        check({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
        check({tag, "_und"}, {31'd0, underrun}, 32'd0);
        check({tag, "_err"}, {31'd0, error_bit}, 32'd0);
    endtask

    initial begin
        logic [10:0] first3[3];
        wb_rst_i     = 1'b1;
        data_in      = '0;
        push         = 1'b0;
        pop          = 1'b0;
        fifo_reset   = 1'b0;
        reset_status = 1'b0;
        m_ovr        = 1'b0;
        m_und        = 1'b0;
        #12;
        check_all_zero("reset");
        wb_rst_i = 1'b0;
        @(posedge clk);
        #1;

        // three pushes then three pops; first entry carries error bits
        first3[0] = 11'h155;
        first3[1] = 11'h0A8;
        first3[2] = 11'h7F8;
        for (int i = 0; i < 3; i++) do_push(first3[i]);
        check("err_with_155", {31'd0, error_bit}, 32'd1);
        for (int i = 0; i < 3; i++) do_pop();

        // fill to 16, push on full -> overrun, head unchanged, then clear
        for (int i = 0; i < 16; i++) do_push(11'((i << 3) | ((i == 7) ? 2 : 0)));
        do_push(11'h123);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        cyc(1'b0, 1'b0, 11'd0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) do_pop();

        // underrun from empty; push+pop on empty keeps underrun, takes push
        do_pop();
        check("und_set", {31'd0, underrun}, 32'd1);
        cyc(1'b1, 1'b1, 11'h2C4, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 11'd0, 1'b0, 1'b1);
        do_pop();

        // full with push+pop: count stays 16, new entry drains last
        for (int i = 0; i < 16; i++) do_push(11'(11'h400 + (i << 3)));
        cyc(1'b1, 1'b1, 11'h3AA, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) do_pop();

        // 20 pushes and 20 pops overlapped so pointers wrap
        for (int i = 0; i < 23; i++) cyc(i < 20, i >= 3, 11'(11'h100 + i * 9), 1'b0, 1'b0);

        // 5 entries with overrun set, then flush together with a push
        for (int i = 0; i < 16; i++) do_push(11'(11'h200 + i));
        do_push(11'h055);
        for (int i = 0; i < 11; i++) do_pop();
        check("pre_flush_cnt", {27'd0, count}, 32'd5);
        cyc(1'b1, 1'b0, 11'h7FF, 1'b1, 1'b0);
        check("flush_cnt", {27'd0, count}, 32'd0);

        // constrained random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0 ? 1 : 0),
                11'($urandom), ($urandom_range(0, 60) == 0), ($urandom_range(0, 9) == 0));
        end

        // asynchronous reset mid-stream with errors and overrun pending
        cyc(1'b0, 1'b0, 11'd0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) do_push(11'(11'h0F1 + (i << 4)));
        do_push(11'h001);
        do_pop();
        #2;
        wb_rst_i = 1'b1;
        #1;
        check_all_zero("arst");
        mq.delete();
        m_ovr = 1'b0;
        m_und = 1'b0;
        #1;
        wb_rst_i = 1'b0;
        @(posedge clk);
        #1;
        do_push(11'h00C);
        do_pop();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
